key_event_decoder: RTL and testbench
====================================

# key_event_decoder

Consumes the one-cycle `key_flag`/`key_value` stream produced by a key debouncer and classifies each key into discrete user events: press, release, single click, double click, long press and auto-repeat. Sits between the debouncer and the stepper/parking control logic, so the control FSMs see one registered pulse per user gesture instead of raw level changes. Counts are in clock cycles (50 MHz system clock). The key is active-low: `key_value` = 0 means pressed.

## Interface
- `LONG_CNT`, default 50_000_000: hold time to declare a long press (1 s).
- `REPEAT_CNT`, default 10_000_000: auto-repeat period while long-held (200 ms).
- `DBL_CNT`, default 15_000_000: release-to-second-press window for a double click (300 ms).
- All parameters must be ≥ 2 and < 2^32. The counter is 32 bits.
- `sys_clk` in 1: system clock. One clock domain only.
- `sys_rst_n` in 1: reset, asynchronous assert, active-low.
- `key_flag` in 1: single-cycle "debounced value valid" strobe.
- `key_value` in 1: debounced key level. Sampled only when `key_flag` = 1.
- `key_state` out 1: registered pressed level (1 = held).
- `press_pulse` out 1: one-cycle pulse on each accepted press.
- `release_pulse` out 1: one-cycle pulse on each accepted release.
- `single_click` out 1: one-cycle pulse; short press with no second press inside `DBL_CNT`.
- `double_click` out 1: one-cycle pulse; second short press released.
- `long_press` out 1: one-cycle pulse when the hold reaches `LONG_CNT`.
- `repeat_pulse` out 1: one-cycle pulse every `REPEAT_CNT` cycles after `long_press` while the key is still held.

## Operation
- Accepted press: `key_flag` = 1 and `key_value` = 0 while `key_state` = 0.
- Accepted release: `key_flag` = 1 and `key_value` = 1 while `key_state` = 1.
- A flag whose value equals the current `key_state` (a debouncer re-confirm) is ignored. It causes no state change and no pulse.
- States and transitions (`cnt` is cleared on every transition, increments every cycle in non-IDLE states, and is held at 0 in IDLE):
  - IDLE:
    - press → PRESSED, `press_pulse`.
  - PRESSED:
    - release → WAIT_DBL, `release_pulse`.
    - `cnt` == `LONG_CNT`-1 → LONG, `long_press`.
  - LONG:
    - `cnt` == `REPEAT_CNT`-1 → stay in LONG, `repeat_pulse`, `cnt` cleared.
    - release → IDLE, `release_pulse`. No click is reported.
  - WAIT_DBL:
    - press → PRESSED2, `press_pulse`.
    - `cnt` == `DBL_CNT`-1 → IDLE, `single_click`.
  - PRESSED2:
    - release → IDLE, `release_pulse` and `double_click` in the same cycle.
    - `cnt` == `LONG_CNT`-1 → LONG, `long_press`. The pending click is discarded.
- Simultaneous accepted flag and counter terminal value in the same cycle: the flag wins. The timeout event is not emitted.
- `key_state` tracks accepted press/release and is independent of the FSM state.
- At most one of `single_click`, `double_click`, `long_press`, `repeat_pulse` is high in any cycle.

## Timing
- Reset: state IDLE, `cnt` = 0, every output = 0. Reset mid-gesture drops the gesture with no pulse.
- The first event after reset needs a fresh press flag.
- All outputs are registered. Latency is 1 cycle from the `key_flag` sampling edge to `press_pulse`/`release_pulse`/`double_click`/`key_state`.
- `long_press` is high exactly `LONG_CNT` cycles after `press_pulse` was high, if no release occurs.
- `repeat_pulse` is high `REPEAT_CNT` cycles after `long_press`, then every `REPEAT_CNT` cycles.
- `single_click` is high `DBL_CNT` cycles after `release_pulse`.
- Release at hold cycle `LONG_CNT`-1 (flag sampled at the terminal cycle): short-press path, no `long_press`.
- Back-to-back flags on consecutive cycles are legal and are each evaluated.

## Test plan
Bench parameters: `LONG_CNT`=20, `REPEAT_CNT`=5, `DBL_CNT`=8.
- Single click: press flag, release flag 5 cycles later, then idle → `press_pulse`, `release_pulse`, and `single_click` 8 cycles after `release_pulse`. No other pulses.
- Double click: press; release at +5; press 3 cycles after release; release at +4 → two `press_pulse`, and `double_click` coincident with the second `release_pulse`. No `single_click`.
- Long press with repeat: press held 32 cycles → `long_press` at +20, `repeat_pulse` at +25 and +30. Release → `release_pulse` only, no click.
- Re-confirm flags: flag with `key_value`=1 in IDLE, and flag with `key_value`=0 while held → no pulses, no state change.
- Boundary race: release flag on the exact cycle `cnt` == 19 in PRESSED → `release_pulse`, no `long_press`. Second-press flag on the `DBL_CNT` terminal cycle → enters PRESSED2, no `single_click`.
- Reset mid-operation: assert `sys_rst_n`=0 during LONG and during WAIT_DBL → all outputs 0 immediately, no pulses after deassert until a new press flag.

Source files
------------

// File: rtl/key_event_decoder.sv
// Turns the debounced key_flag/key_value stream into one registered pulse per user gesture:
// press, release, single/double click, long press and auto-repeat.
module key_event_decoder #(
    parameter int unsigned LONG_CNT   = 50_000_000,
    parameter int unsigned REPEAT_CNT = 10_000_000,
    parameter int unsigned DBL_CNT    = 15_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_flag,
    input  logic key_value,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic repeat_pulse
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESSED  = 3'd1,
        LONG     = 3'd2,
        WAIT_DBL = 3'd3,
        PRESSED2 = 3'd4
    } state_t;

    localparam logic [31:0] LONG_LAST   = 32'(LONG_CNT - 1);
    localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_CNT - 1);
    localparam logic [31:0] DBL_LAST    = 32'(DBL_CNT - 1);

    state_t      state_reg;
    logic [31:0] cnt_reg;
    logic        press_acc;
    logic        release_acc;

    // Flags that merely re-confirm the current level are dropped here.
    assign press_acc   = key_flag & ~key_value & ~key_state;
    assign release_acc = key_flag &  key_value &  key_state;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg     <= IDLE;
            cnt_reg       <= 32'd0;
            key_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            single_click  <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            single_click  <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
            repeat_pulse  <= 1'b0;

            if (press_acc) begin
                key_state <= 1'b1;
            end else if (release_acc) begin
                key_state <= 1'b0;
            end

            // Accepted flags are tested before counter terminals so the flag wins a tie.
            case (state_reg)
                IDLE: begin
                    cnt_reg <= 32'd0;
                    if (press_acc) begin
                        state_reg   <= PRESSED;
                        press_pulse <= 1'b1;
                    end
                end
                PRESSED: begin
                    if (release_acc) begin
                        state_reg     <= WAIT_DBL;
                        release_pulse <= 1'b1;
                        cnt_reg       <= 32'd0;
                    end else if (cnt_reg == LONG_LAST) begin
                        state_reg  <= LONG;
                        long_press <= 1'b1;
                        cnt_reg    <= 32'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                LONG: begin
                    if (release_acc) begin
                        state_reg     <= IDLE;
                        release_pulse <= 1'b1;
                        cnt_reg       <= 32'd0;
                    end else if (cnt_reg == REPEAT_LAST) begin
                        repeat_pulse <= 1'b1;
                        cnt_reg      <= 32'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                WAIT_DBL: begin
                    if (press_acc) begin
                        state_reg   <= PRESSED2;
                        press_pulse <= 1'b1;
                        cnt_reg     <= 32'd0;
                    end else if (cnt_reg == DBL_LAST) begin
                        state_reg    <= IDLE;
                        single_click <= 1'b1;
                        cnt_reg      <= 32'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                PRESSED2: begin
                    if (release_acc) begin
                        state_reg     <= IDLE;
                        release_pulse <= 1'b1;
                        double_click  <= 1'b1;
                        cnt_reg       <= 32'd0;
                    end else if (cnt_reg == LONG_LAST) begin
                        state_reg  <= LONG;
                        long_press <= 1'b1;
                        cnt_reg    <= 32'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Directed-vector bench for key_event_decoder with LONG_CNT=20, REPEAT_CNT=5, DBL_CNT=8.
module tb_key_event_decoder;

    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    logic key_flag = 1'b0;
    logic key_value = 1'b1;
    logic key_state, press_pulse, release_pulse, single_click;
    logic double_click, long_press, repeat_pulse;

    key_event_decoder #(.LONG_CNT(20), .REPEAT_CNT(5), .DBL_CNT(8)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .key_flag(key_flag), .key_value(key_value),
        .key_state(key_state), .press_pulse(press_pulse), .release_pulse(release_pulse),
        .single_click(single_click), .double_click(double_click),
        .long_press(long_press), .repeat_pulse(repeat_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int multi_evt = 0;
    int n_press, n_rel, n_single, n_double, n_long, n_rep;
    int t_press, t_rel, t_single, t_double, t_long, t_rep, t_rep_first;
    int t0, r0;

    task automatic check_value(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        n_press = 0; n_rel = 0; n_single = 0; n_double = 0; n_long = 0; n_rep = 0;
        t_press = -1; t_rel = -1; t_single = -1; t_double = -1; t_long = -1;
        t_rep = -1; t_rep_first = -1;
    endtask

    // Drive one cycle of input, then sample and log every pulse 1 time unit after the edge.
    task automatic clk_step(input logic flag, input logic val);
        key_flag = flag;
        key_value = val;
        @(posedge sys_clk);
        #1;
        key_flag = 1'b0;
        cyc++;
        if (press_pulse)   begin n_press++;  t_press = cyc;  end
        if (release_pulse) begin n_rel++;    t_rel = cyc;    end
        if (single_click)  begin n_single++; t_single = cyc; end
        if (double_click)  begin n_double++; t_double = cyc; end
        if (long_press)    begin n_long++;   t_long = cyc;   end
        if (repeat_pulse)  begin
            n_rep++; t_rep = cyc;
            if (t_rep_first < 0) t_rep_first = cyc;
        end
        if (int'(single_click) + int'(double_click) + int'(long_press) + int'(repeat_pulse) > 1)
            multi_evt++;
        if (flag || press_pulse || release_pulse || single_click || double_click || long_press || repeat_pulse)
            $display("cyc=%0d flag=%0b val=%0b state=%0b pr=%0b rl=%0b sc=%0b dc=%0b lp=%0b rp=%0b",
                     cyc, flag, val, key_state, press_pulse, release_pulse, single_click,
                     double_click, long_press, repeat_pulse);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) clk_step(1'b0, key_value);
    endtask

    initial begin
        clear_stats();
        #12;
        check_value("reset_key_state", int'(key_state), 0);
        check_value("reset_outputs", int'({press_pulse, release_pulse, single_click,
                                            double_click, long_press, repeat_pulse}), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle(2);

        // Single click
        clear_stats();
        clk_step(1'b1, 1'b0); t0 = cyc;
        check_value("sc_press_time", t_press, t0);
        check_value("sc_key_state_held", int'(key_state), 1);
        idle(4);
        clk_step(1'b1, 1'b1);
        check_value("sc_release_time", t_rel, t0 + 5);
        check_value("sc_key_state_rel", int'(key_state), 0);
        idle(12);
        check_value("sc_single_count", n_single, 1);
        check_value("sc_single_time", t_single, t0 + 13);
        check_value("sc_other_events", n_double + n_long + n_rep, 0);

        // Double click
        clear_stats();
        clk_step(1'b1, 1'b0); t0 = cyc;
        idle(4);
        clk_step(1'b1, 1'b1);
        idle(2);
        clk_step(1'b1, 1'b0);
        check_value("dc_second_press", t_press, t0 + 8);
        idle(3);
        clk_step(1'b1, 1'b1);
        idle(12);
        check_value("dc_press_count", n_press, 2);
        check_value("dc_release_count", n_rel, 2);
        check_value("dc_double_count", n_double, 1);
        check_value("dc_double_time", t_double, t0 + 12);
        check_value("dc_with_release", t_double, t_rel);
        check_value("dc_no_single", n_single, 0);

        // Long press with repeat
        clear_stats();
        clk_step(1'b1, 1'b0); t0 = cyc;
        idle(31);
        clk_step(1'b1, 1'b1);
        idle(12);
        check_value("lp_long_count", n_long, 1);
        check_value("lp_long_time", t_long, t0 + 20);
        check_value("lp_repeat_count", n_rep, 2);
        check_value("lp_repeat_first", t_rep_first, t0 + 25);
        check_value("lp_repeat_last", t_rep, t0 + 30);
        check_value("lp_release_time", t_rel, t0 + 32);
        check_value("lp_no_click", n_single + n_double, 0);

        // Re-confirm flags
        clear_stats();
        clk_step(1'b1, 1'b1);
        idle(10);
        check_value("rc_idle_pulses", n_press + n_rel + n_single + n_double + n_long + n_rep, 0);
        check_value("rc_idle_state", int'(key_state), 0);
        clk_step(1'b1, 1'b0); t0 = cyc;
        idle(2);
        clk_step(1'b1, 1'b0);
        check_value("rc_held_press_count", n_press, 1);
        check_value("rc_held_state", int'(key_state), 1);
        idle(1);
        clk_step(1'b1, 1'b1);
        idle(12);
        check_value("rc_single_time", t_single, t0 + 13);

        // Boundary races
        clear_stats();
        clk_step(1'b1, 1'b0); t0 = cyc;
        idle(19);
        clk_step(1'b1, 1'b1); r0 = cyc;
        check_value("br_release_time", t_rel, t0 + 20);
        idle(7);
        clk_step(1'b1, 1'b0);
        check_value("br_second_press_time", t_press, r0 + 8);
        check_value("br_second_state", int'(key_state), 1);
        idle(2);
        clk_step(1'b1, 1'b1);
        idle(12);
        check_value("br_no_long", n_long, 0);
        check_value("br_no_single", n_single, 0);
        check_value("br_double", n_double, 1);

        // Reset during LONG
        clear_stats();
        clk_step(1'b1, 1'b0);
        idle(21);
        check_value("rs_long_reached", n_long, 1);
        sys_rst_n = 1'b0;
        #2;
        check_value("rs_long_key_state", int'(key_state), 0);
        check_value("rs_long_outputs", int'({press_pulse, release_pulse, single_click,
                                             double_click, long_press, repeat_pulse}), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clear_stats();
        clk_step(1'b1, 1'b1);
        idle(30);
        check_value("rs_long_quiet", n_press + n_rel + n_single + n_double + n_long + n_rep, 0);

        // Reset during WAIT_DBL
        clk_step(1'b1, 1'b0);
        idle(2);
        clk_step(1'b1, 1'b1);
        idle(2);
        sys_rst_n = 1'b0;
        #2;
        check_value("rs_dbl_outputs", int'({key_state, press_pulse, release_pulse, single_click,
                                            double_click, long_press, repeat_pulse}), 0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        clear_stats();
        idle(15);
        check_value("rs_dbl_quiet", n_press + n_rel + n_single + n_double + n_long + n_rep, 0);
        clk_step(1'b1, 1'b0); t0 = cyc;
        check_value("rs_fresh_press", t_press, t0);

        check_value("exclusive_events", multi_evt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
